// File: rtl/cosine_pkg.sv
// ============================================================================
// Package     : cosine_pkg
// Description : Shared widths, channel ids and helpers for the cosine datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cosine_pkg;

  localparam int         DATA_W     = 16;
  localparam logic       CH0        = 1'b0;
  localparam logic       CH1        = 1'b1;
  localparam int         STAT_W     = 16;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_fifo2.sv
// ============================================================================
// Module      : demux_fifo2
// Description : Two-entry FIFO with 1-bit wrapping pointers; head reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_fifo2
  import cosine_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [n-1:0] i_push_data,
  output logic         o_full,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [n-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [n-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // Guard both strobes locally so misuse can never corrupt the count.
  assign w_push = i_push & (r_count != FIFO_DEPTH);
  assign w_pop  = i_pop  & (r_count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == FIFO_DEPTH);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// Module      : stream_demux
// Description : 1:2 stream demultiplexer, one 2-entry FIFO per output channel.
//               Optional macro DEMUX_STATS_EN adds saturating pop counters stat0/stat1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux
  import cosine_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [n-1:0]      in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [n-1:0]      out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [n-1:0]      out1_data,
  output logic              out1_valid,
  input  logic              out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1
`endif
);

  logic       w_push0;
  logic       w_push1;
  logic       w_full0;
  logic       w_full1;
  logic [1:0] w_count0;
  logic [1:0] w_count1;

  // Readiness looks only at the registered count of the addressed channel,
  // so a same-cycle pop on a full channel does not open the input.
  assign in_ready = (in_sel == CH1) ? (w_count1 != FIFO_DEPTH)
                                    : (w_count0 != FIFO_DEPTH);

  assign w_push0 = in_valid & in_ready & (in_sel == CH0);
  assign w_push1 = in_valid & in_ready & (in_sel == CH1);

  demux_fifo2 #(.n(n)) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .o_full      (w_full0),
    .i_pop       (out0_ready),
    .o_valid     (out0_valid),
    .o_head      (out0_data),
    .o_count     (w_count0)
  );

  demux_fifo2 #(.n(n)) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .o_full      (w_full1),
    .i_pop       (out1_ready),
    .o_valid     (out1_valid),
    .o_head      (out1_data),
    .o_count     (w_count1)
  );

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] r_stat0;
  logic [STAT_W-1:0] r_stat1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (out0_valid & out0_ready) r_stat0 <= sat_inc(r_stat0);
      if (out1_valid & out1_ready) r_stat1 <= sat_inc(r_stat1);
    end
  end

  assign stat0 = r_stat0;
  assign stat1 = r_stat1;
`endif

  logic w_unused;
  assign w_unused = w_full0 ^ w_full1;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// Module      : tb_stream_demux
// Description : Self-checking bench for stream_demux (queue model + directed vectors).
//               Stat counter checks are active when DEMUX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
`ifdef DEMUX_STATS_EN
  logic [15:0] stat0;
  logic [15:0] stat1;
`endif

  int errors = 0;
  int checks = 0;
  logic run = 1'b0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int unsigned mstat0 = 0;
  int unsigned mstat1 = 0;
  int          n_acc = 0;

  stream_demux #(.n(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
    ,
    .stat0      (stat0),
    .stat1      (stat1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-channel queues of capacity 2; pops see the pre-edge state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      mstat0 = 0;
      mstat1 = 0;
    end else begin
      bit acc, p0, p1;
      acc = in_valid && ((in_sel ? q1.size() : q0.size()) < 2);
      p0  = out0_ready && (q0.size() > 0);
      p1  = out1_ready && (q1.size() > 0);
      if (p0) begin void'(q0.pop_front()); if (mstat0 < 65535) mstat0++; end
      if (p1) begin void'(q1.pop_front()); if (mstat1 < 65535) mstat1++; end
      if (acc) begin
        n_acc++;
        if (in_sel) q1.push_back(in_data); else q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && run) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, ((in_sel ? q1.size() : q0.size()) < 2)});
      check("out0_valid", {31'd0, out0_valid}, {31'd0, (q0.size() > 0)});
      if (q0.size() > 0) check("out0_data", {16'd0, out0_data}, {16'd0, q0[0]});
      check("out1_valid", {31'd0, out1_valid}, {31'd0, (q1.size() > 0)});
      if (q1.size() > 0) check("out1_data", {16'd0, out1_data}, {16'd0, q1[0]});
`ifdef DEMUX_STATS_EN
      check("stat0", {16'd0, stat0}, mstat0);
      check("stat1", {16'd0, stat1}, mstat1);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cyc();
  endtask

  initial begin
    int guard;
    // Power-on reset
    #2;
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out0_data", {16'd0, out0_data}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    do_reset();
    run = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Routing
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h1234);
    cyc();
    drive(1'b1, 1'b1, 16'hABCD);
    check("route_c1_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("route_c1_out0_data", {16'd0, out0_data}, 32'h1234);
    check("route_c1_out1_valid", {31'd0, out1_valid}, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    check("route_c2_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("route_c2_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("route_c2_out1_data", {16'd0, out1_data}, 32'hABCD);
    cyc();
    check("route_c3_out1_valid", {31'd0, out1_valid}, 32'd0);

    // Full / backpressure on ch0
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0001); cyc();
    drive(1'b1, 1'b0, 16'h0002); cyc();
    drive(1'b1, 1'b0, 16'h0003); #1;
    check("full_in_ready_ch0", {31'd0, in_ready}, 32'd0);
    out0_ready = 1'b1; #1;
    check("full_pop_no_bypass", {31'd0, in_ready}, 32'd0);
    out0_ready = 1'b0;
    drive(1'b1, 1'b1, 16'h00FF); #1;
    check("full_in_ready_ch1", {31'd0, in_ready}, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    check("full_out1_data", {16'd0, out1_data}, 32'h00FF);
    check("full_out0_head", {16'd0, out0_data}, 32'h0001);
    out0_ready = 1'b1; cyc();
    check("full_drain0", {16'd0, out0_data}, 32'h0002);
    out1_ready = 1'b1; cyc(); cyc();
    check("full_drained0", {31'd0, out0_valid}, 32'd0);
    check("full_drained1", {31'd0, out1_valid}, 32'd0);

    // Simultaneous push and pop with count 1
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0004); cyc();
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0005); cyc();
    drive(1'b0, 1'b0, 16'h0);
    check("pp_valid", {31'd0, out0_valid}, 32'd1);
    check("pp_data", {16'd0, out0_data}, 32'h0005);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("pp_empty", {31'd0, out0_valid}, 32'd0);

    // Asynchronous reset with two words queued on ch0
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0A0A); cyc();
    drive(1'b1, 1'b0, 16'h0B0B); cyc();
    drive(1'b0, 1'b0, 16'h0); #1;
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("arst_out0_data", {16'd0, out0_data}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    cyc();
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_still_empty", {31'd0, out0_valid}, 32'd0);

    // Random stress: 1000 accepted words
    n_acc = 0;
    guard = 0;
    while (n_acc < 1000 && guard < 8000) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom));
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      cyc();
      guard++;
    end
    check("stress_completed", {31'd0, (n_acc >= 1000)}, 32'd1);
    drive(1'b0, 1'b0, 16'h0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) cyc();
    check("stress_end_out0", {31'd0, out0_valid}, 32'd0);
    check("stress_end_out1", {31'd0, out1_valid}, 32'd0);

`ifdef DEMUX_STATS_EN
    do_reset();
    check("stat_rst0", {16'd0, stat0}, 32'd0);
    check("stat_rst1", {16'd0, stat1}, 32'd0);
    drive(1'b1, 1'b1, 16'h0011); cyc();
    drive(1'b1, 1'b1, 16'h0022); cyc();
    drive(1'b0, 1'b0, 16'h0);
    out1_ready = 1'b1; cyc(); cyc();
    drive(1'b1, 1'b1, 16'h0033); cyc();
    drive(1'b0, 1'b0, 16'h0); cyc();
    check("stat1_three", {16'd0, stat1}, 32'd3);
    check("stat0_zero", {16'd0, stat0}, 32'd0);
    guard = 0;
    while (mstat1 < 32'hFFFE && guard < 70000) begin
      drive(1'b1, 1'b1, 16'($urandom));
      cyc();
      guard++;
    end
    check("stat1_fffe", {16'd0, stat1}, 32'hFFFE);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    cyc();
    check("stat1_saturated", {16'd0, stat1}, 32'hFFFF);
    check("stat0_untouched", {16'd0, stat0}, 32'd0);
`endif

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
